axi_rd_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI4 read port (AR + R channels) of the slave RAM between NUM_REQ read masters, e.g. a weight-fetch engine and a bias-fetch engine.
- Sits between the requesters and the slave memory.
- Allows one outstanding burst at a time. A grant is held from AR acceptance until the RLAST beat completes.
- Checks burst length against RLAST and reports mismatches.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/axi_rd_arbiter.sv | 151 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, channel widths and the arbiter state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXLEN_W  = 8;
    localparam int AXSIZE_W = 3;
    localparam int PROT_W   = 3;
    localparam int CACHE_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request above last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [$clog2(NUM_REQ)-1:0] winner_o,
    output logic                       any_req_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] cand;

    always_comb begin
        winner_o  = last_grant_i;
        any_req_o = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant_i) + k) % NUM_REQ);
            if (!any_req_o && req_i[cand]) begin
                winner_o  = cand;
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between NUM_REQ masters, one burst in flight at a time,
// and flags bursts whose RLAST disagrees with the accepted ARLEN.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_REQ          = 2,
    parameter int C_AXI_ADDR_WIDTH = 12,
    parameter int C_AXI_DATA_WIDTH = 128,
    parameter int C_AXI_ID_WIDTH   = 1
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [NUM_REQ-1:0]                    s_axi_arvalid,
    output logic [NUM_REQ-1:0]                    s_axi_arready,
    input  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [NUM_REQ*AXLEN_W-1:0]            s_axi_arlen,
    input  logic [NUM_REQ*AXSIZE_W-1:0]           s_axi_arsize,
    input  logic [NUM_REQ*2-1:0]                  s_axi_arburst,
    input  logic [NUM_REQ*C_AXI_ID_WIDTH-1:0]     s_axi_arid,
    output logic [NUM_REQ-1:0]                    s_axi_rvalid,
    input  logic [NUM_REQ-1:0]                    s_axi_rready,
    output logic [C_AXI_DATA_WIDTH-1:0]           s_axi_rdata,
    output logic [1:0]                            s_axi_rresp,
    output logic                                  s_axi_rlast,
    output logic [C_AXI_ID_WIDTH-1:0]             s_axi_rid,
    output logic                                  m_axi_arvalid,
    input  logic                                  m_axi_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic [AXLEN_W-1:0]                    m_axi_arlen,
    output logic [AXSIZE_W-1:0]                   m_axi_arsize,
    output logic [1:0]                            m_axi_arburst,
    output logic [C_AXI_ID_WIDTH-1:0]             m_axi_arid,
    output logic                                  m_axi_arlock,
    output logic [CACHE_W-1:0]                    m_axi_arcache,
    output logic [PROT_W-1:0]                     m_axi_arprot,
    input  logic                                  m_axi_rvalid,
    output logic                                  m_axi_rready,
    input  logic [C_AXI_DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic [1:0]                            m_axi_rresp,
    input  logic                                  m_axi_rlast,
    input  logic [C_AXI_ID_WIDTH-1:0]             m_axi_rid,
    output logic [$clog2(NUM_REQ)-1:0]            grant_idx,
    output logic                                  busy,
    output logic                                  burst_err,
    output logic [1:0]                            dbg_state
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e    state_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_grant_q;
    logic [7:0]    exp_len_q;
    logic [8:0]    beat_cnt_q;
    logic          busy_q;
    logic          burst_err_q;

    logic [IW-1:0] winner;
    logic          any_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i        (s_axi_arvalid),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    always_comb begin
        m_axi_araddr  = s_axi_araddr[int'(grant_q)*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
        m_axi_arlen   = s_axi_arlen[int'(grant_q)*AXLEN_W +: AXLEN_W];
        m_axi_arsize  = s_axi_arsize[int'(grant_q)*AXSIZE_W +: AXSIZE_W];
        m_axi_arburst = s_axi_arburst[int'(grant_q)*2 +: 2];
        m_axi_arid    = s_axi_arid[int'(grant_q)*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH];
    end

    // Handshake routing: only the granted requester sees its channel, and only in its phase.
    always_comb begin
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        case (state_q)
            ADDR: begin
                m_axi_arvalid          = s_axi_arvalid[grant_q];
                s_axi_arready[grant_q] = m_axi_arready;
            end
            DATA: begin
                s_axi_rvalid[grant_q] = m_axi_rvalid;
                m_axi_rready          = s_axi_rready[grant_q];
            end
            default: ;
        endcase
    end

    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rid     = m_axi_rid;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = '0;
    assign m_axi_arprot  = '0;
    assign grant_idx     = grant_q;
    assign busy          = busy_q;
    assign burst_err     = burst_err_q;
    assign dbg_state     = state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            exp_len_q    <= '0;
            beat_cnt_q   <= '0;
            busy_q       <= 1'b0;
            burst_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        busy_q  <= 1'b1;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        exp_len_q  <= m_axi_arlen;
                        beat_cnt_q <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    // beat_cnt_q holds the index of the beat being accepted this cycle.
                    if (m_axi_rvalid && m_axi_rready) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (m_axi_rlast) begin
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                            last_grant_q <= grant_q;
                            if (beat_cnt_q != {1'b0, exp_len_q}) burst_err_q <= 1'b1;
                        end else if (beat_cnt_q == {1'b0, exp_len_q}) begin
                            burst_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: burst table plus hand sequences, AR/R scoreboards.
module tb_axi_rd_arbiter;
    import axi_pkg::*;

    localparam int NR  = 2;
    localparam int AW  = 12;
    localparam int DW  = 128;
    localparam int IDW = 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NR-1:0]     s_axi_arvalid;
    logic [NR-1:0]     s_axi_arready;
    logic [NR*AW-1:0]  s_axi_araddr;
    logic [NR*8-1:0]   s_axi_arlen;
    logic [NR*3-1:0]   s_axi_arsize;
    logic [NR*2-1:0]   s_axi_arburst;
    logic [NR*IDW-1:0] s_axi_arid;
    logic [NR-1:0]     s_axi_rvalid;
    logic [NR-1:0]     s_axi_rready;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic [IDW-1:0]    s_axi_rid;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic [IDW-1:0]    m_axi_arid;
    logic              m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DW-1:0]     m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic [IDW-1:0]    m_axi_rid;
    logic [0:0]        grant_idx;
    logic              busy;
    logic              burst_err;
    logic [1:0]        dbg_state;

    axi_rd_arbiter #(
        .NUM_REQ(NR), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arid(s_axi_arid),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arid(m_axi_arid), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
        .grant_idx(grant_idx), .busy(busy), .burst_err(burst_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]  ar_q[$];
    logic [143:0] r_q[$];

    logic [AW-1:0]  req_addr [NR];
    logic [7:0]     req_len  [NR];
    logic [2:0]     req_size [NR];
    logic [1:0]     req_burst[NR];
    logic [IDW-1:0] req_id   [NR];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        s_axi_arvalid = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = '0;
        s_axi_arburst = '0;
        s_axi_arid    = '0;
        s_axi_rready  = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = RESP_OKAY;
        m_axi_rlast   = 1'b0;
        m_axi_rid     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_burst_err", 160'(burst_err), 160'(0));
        chk("rst_grant_idx", 160'(grant_idx), 160'(0));
        chk("rst_state", 160'(dbg_state), 160'(0));
        chk("rst_valid_ready", 160'({s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready}), 160'(0));
        chk("rst_ar_consts", 160'({m_axi_arlock, m_axi_arcache, m_axi_arprot}), 160'(0));
        resetn = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input logic [AW-1:0] addr, input logic [7:0] len);
        req_addr[r]  = addr;
        req_len[r]   = len;
        req_size[r]  = (r == 0) ? 3'd4 : 3'd3;
        req_burst[r] = (r == 0) ? BURST_INCR : BURST_WRAP;
        req_id[r]    = IDW'(r);
        s_axi_araddr[r*AW +: AW]    = addr;
        s_axi_arlen[r*8 +: 8]       = len;
        s_axi_arsize[r*3 +: 3]      = req_size[r];
        s_axi_arburst[r*2 +: 2]     = req_burst[r];
        s_axi_arid[r*IDW +: IDW]    = req_id[r];
    endtask

    // Accepts one AR from the expected requester; waited = extra negedges before arvalid.
    task automatic ar_accept(input int exp_req, output int waited);
        int n = 0;
        ar_q.push_back({6'b0, req_addr[exp_req], req_len[exp_req], req_size[exp_req],
                        req_burst[exp_req], req_id[exp_req]});
        m_axi_arready = 1'b1;
        @(negedge clk);
        while (!m_axi_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        chk("ar_handshake", 160'(m_axi_arvalid), 160'(1));
        chk("ar_grant_idx", 160'(grant_idx), 160'(exp_req));
        chk("ar_s_arready", 160'(s_axi_arready), 160'(NR'(1) << exp_req));
        @(posedge clk);
        #1;
        m_axi_arready = 1'b0;
    endtask

    task automatic r_beat(input int r, input logic [DW-1:0] data, input logic last, input int stall);
        int n = 0;
        r_q.push_back({8'(r), 8'(req_id[r]), data});
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = data;
        m_axi_rlast  = last;
        m_axi_rid    = req_id[r];
        s_axi_rready = '0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("r_stall_m_rready", 160'(m_axi_rready), 160'(0));
            chk("r_stall_s_rvalid", 160'(s_axi_rvalid), 160'(NR'(1) << r));
            @(posedge clk);
            #1;
        end
        s_axi_rready[r] = 1'b1;
        @(negedge clk);
        while (!m_axi_rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("r_handshake", 160'(m_axi_rready), 160'(1));
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        s_axi_rready = '0;
    endtask

    function automatic logic [DW-1:0] rand_data(input int r, input int b);
        return {32'($urandom), 32'($urandom_range(0, 32'hFFFF)), 32'(r), 32'(b)};
    endfunction

    task automatic run_burst(input int r, input logic [AW-1:0] addr, input logic [7:0] len,
                             input int beats);
        int w;
        set_req(r, addr, len);
        s_axi_arvalid[r] = 1'b1;
        ar_accept(r, w);
        s_axi_arvalid[r] = 1'b0;
        for (int b = 0; b < beats; b++) r_beat(r, rand_data(r, b), (b == beats - 1), 0);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (m_axi_arvalid && m_axi_arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 160'(ar_q.size()), 160'(1));
            else chk("ar_fields", 160'({6'b0, m_axi_araddr, m_axi_arlen, m_axi_arsize,
                                         m_axi_arburst, m_axi_arid}), 160'(ar_q.pop_front()));
        end
        for (int i = 0; i < NR; i++) begin
            if (s_axi_rvalid[i] && s_axi_rready[i]) begin
                if (r_q.size() == 0) chk("r_unexpected", 160'(r_q.size()), 160'(1));
                else chk("r_beat_data", 160'({8'(i), 8'(s_axi_rid), s_axi_rdata}), 160'(r_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    typedef struct {
        int          req;
        logic [11:0] addr;
        logic [7:0]  len;
        int          beats;
        logic        exp_err;
    } vec_t;

    vec_t vec[5];

    initial begin
        int w;
        vec[0] = '{0, 12'h100, 8'd3,   4,   1'b0};
        vec[1] = '{1, 12'h2A0, 8'd0,   1,   1'b0};
        vec[2] = '{0, 12'h3FC, 8'd255, 256, 1'b0};
        vec[3] = '{1, 12'h010, 8'd3,   2,   1'b1};
        vec[4] = '{0, 12'hFFF, 8'd1,   2,   1'b0};

        for (int t = 0; t < 5; t++) begin
            do_reset();
            run_burst(vec[t].req, vec[t].addr, vec[t].len, vec[t].beats);
            chk("tbl_busy_after", 160'(busy), 160'(0));
            chk("tbl_state_idle", 160'(dbg_state), 160'(0));
            chk("tbl_burst_err", 160'(burst_err), 160'(vec[t].exp_err));
            chk("tbl_grant_idx", 160'(grant_idx), 160'(vec[t].req));
        end

        // Contention: both request right after reset; grants alternate.
        do_reset();
        set_req(0, 12'h200, 8'd0);
        set_req(1, 12'h300, 8'd0);
        s_axi_arvalid = 2'b11;
        @(negedge clk);
        chk("cont_arb_cycle", 160'(m_axi_arvalid), 160'(0));
        for (int k = 0; k < 4; k++) begin
            ar_accept(k % 2, w);
            if (k == 0) chk("cont_first_latency", 160'(w), 160'(0));
            r_beat(k % 2, rand_data(k % 2, 0), 1'b1, 0);
        end
        s_axi_arvalid = '0;

        // AR backpressure: five refused cycles, handshake on the sixth.
        do_reset();
        set_req(0, 12'h155, 8'd1);
        s_axi_arvalid[0] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("arbp_m_arvalid", 160'(m_axi_arvalid), 160'(1));
            chk("arbp_araddr", 160'(m_axi_araddr), 160'(12'h155));
            chk("arbp_s_arready", 160'(s_axi_arready[0]), 160'(0));
        end
        @(posedge clk);
        #1;
        ar_accept(0, w);
        chk("arbp_sixth_cycle", 160'(w), 160'(0));
        s_axi_arvalid = '0;
        r_beat(0, rand_data(0, 0), 1'b0, 0);
        r_beat(0, rand_data(0, 1), 1'b1, 0);
        chk("arbp_burst_err", 160'(burst_err), 160'(0));

        // R backpressure on requester 1: ordered 0xA0..0xA3, no loss or duplication.
        do_reset();
        set_req(1, 12'h0A0, 8'd3);
        s_axi_arvalid[1] = 1'b1;
        ar_accept(1, w);
        s_axi_arvalid = '0;
        for (int b = 0; b < 4; b++) r_beat(1, DW'(8'hA0 + b), (b == 3), (b == 0) ? 3 : 0);
        chk("rbp_burst_err", 160'(burst_err), 160'(0));

        // Late RLAST: len 0, two beats; error from the first beat on.
        do_reset();
        set_req(0, 12'h080, 8'd0);
        s_axi_arvalid[0] = 1'b1;
        ar_accept(0, w);
        s_axi_arvalid = '0;
        r_beat(0, rand_data(0, 0), 1'b0, 0);
        chk("late_err_beat1", 160'(burst_err), 160'(1));
        chk("late_busy_beat1", 160'(busy), 160'(1));
        r_beat(0, rand_data(0, 1), 1'b1, 0);
        chk("late_busy_end", 160'(busy), 160'(0));
        chk("late_err_sticky", 160'(burst_err), 160'(1));

        // Reset during beat 1 of 4, then req0 wins first.
        do_reset();
        set_req(0, 12'h040, 8'd3);
        s_axi_arvalid[0] = 1'b1;
        ar_accept(0, w);
        s_axi_arvalid = '0;
        r_beat(0, rand_data(0, 0), 1'b0, 0);
        m_axi_rvalid    = 1'b1;
        m_axi_rdata     = rand_data(0, 1);
        s_axi_rready[0] = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_busy", 160'(busy), 160'(0));
        chk("midrst_grant", 160'(grant_idx), 160'(0));
        chk("midrst_valid_ready", 160'({s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready}), 160'(0));
        m_axi_rvalid = 1'b0;
        s_axi_rready = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        set_req(0, 12'h044, 8'd0);
        set_req(1, 12'h144, 8'd0);
        s_axi_arvalid = 2'b11;
        ar_accept(0, w);
        s_axi_arvalid[0] = 1'b0;
        r_beat(0, rand_data(0, 0), 1'b1, 0);
        ar_accept(1, w);
        s_axi_arvalid = '0;
        r_beat(1, rand_data(1, 0), 1'b1, 0);

        @(negedge clk);
        chk("ar_q_drained", 160'(ar_q.size()), 160'(0));
        chk("r_q_drained", 160'(r_q.size()), 160'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
